arm_alu_pipe: RTL and testbench
===============================

ARM_ALU_PIPE -- requirements
Module: arm_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have parameter SET_C_LOGICAL, default 1; when 1, logical ops with set_flags load C from shifter_carry, when 0 they leave C unchanged.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation presented.
REQ-006 SHALL have port in_ready  output  1  operation accepted this cycle when in_valid && in_ready.
REQ-007 SHALL have port op_sel  input  4  ARM data-processing opcode: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
REQ-008 SHALL have port op1, op2  input  WIDTH  Rn operand and shifted operand.
REQ-009 SHALL have port shifter_carry  input  1  barrel-shifter carry-out for the op.
REQ-010 SHALL have port set_flags  input  1  S bit; update NZCV on acceptance.
REQ-011 SHALL have port flag_wr, flag_wdata  input  1, 4  external NZCV load (MSR path).
REQ-012 SHALL have port out_valid  output  1  result register holds a result.
REQ-013 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-014 SHALL have port alu_out  output  WIDTH  registered result.
REQ-015 SHALL have port rd_we  output  1  registered; 0 for TST/TEQ/CMP/CMN, else 1.
REQ-016 SHALL have port flags  output  4  current NZCV register, {N,Z,C,V}.

Function
REQ-017 SHALL compute AND/TST a&b, EOR/TEQ a^b, ORR a|b, BIC a&~b, MOV b, MVN ~b, all WIDTH bits.
REQ-018 SHALL compute SUB/CMP a+~b+1, RSB b+~a+1, ADD/CMN a+b, ADC a+b+C, SBC a+~b+C, RSC b+~a+C, in WIDTH+1 bits, C taken from the flags register at acceptance.
REQ-019 SHALL set N = result[WIDTH-1] and Z = (result==0) for every op accepted with set_flags.
REQ-020 SHALL set arithmetic C = bit WIDTH of the sum (for subtract forms C=1 means no borrow), and V = (sign a'==sign b') && (sign sum != sign a'), where a', b' are the actual adder inputs.
REQ-021 SHALL leave V unchanged for logical ops; C follows REQ-002.
REQ-022 SHALL leave NZCV unchanged on accepted ops with set_flags=0.
REQ-023 SHALL have latency exactly 1: op accepted in cycle n appears on alu_out/rd_we with out_valid=1 in cycle n+1; NZCV reflects it from cycle n+1.
REQ-024 SHALL drive in_ready = !flag_wr && (!out_valid || out_ready), giving full throughput with no bubbles while out_ready=1.
REQ-025 SHALL hold alu_out, rd_we, out_valid stable while out_valid && !out_ready.
REQ-026 SHALL clear out_valid when the result is taken and no new op is accepted that cycle.
REQ-027 SHALL, on back-to-back ADC/SBC/RSC, use carry written by the immediately preceding accepted op (no stale-flag hazard).
REQ-028 SHALL load flag_wdata into NZCV when flag_wr=1; since in_ready is 0 then, no op is accepted and no conflict exists.
REQ-029 SHALL wrap results modulo 2^WIDTH; no saturation.

Reset
REQ-030 SHALL, with reset high at a clock edge, force out_valid=0, alu_out=0, rd_we=0, flags=4'b0000, and drop any held or in-flight result.
REQ-031 SHALL hold in_ready=0 in every cycle in which reset is high, and SHALL ignore flag_wr while reset is high.

Structure
REQ-032 SHALL take opcode constants from the shared ARM definitions package (same encoding as existing ALU defines); flag bit indices N=3 Z=2 C=1 V=0 SHALL be added there.
REQ-033 SHALL place the combinational result and NZCV-next logic in one sub-module arm_alu_core (WIDTH-parametrised); arm_alu_pipe holds the registers and the handshake.

Verification
REQ-034 SHALL cover WIDTH=32: ADD 0x7FFFFFFF+1 with S=1 -> alu_out 0x80000000, NZCV=1001 the next cycle.
REQ-035 SHALL cover SUB then SBC: SUB 0-1 with S=1 (C=0), then SBC 5-2 -> 0xFFFFFFFF and 2; NZCV after SBC = 0010.
REQ-036 SHALL cover CMP 5,5 with S=1 -> rd_we=0, Z=1, C=1; TST 0xF0,0x0F with shifter_carry=1 -> Z=1, C=1, V unchanged.
REQ-037 SHALL cover out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and alu_out held; on release, 1 result per cycle with no loss or duplication.
REQ-038 SHALL cover flag_wr=1 (flag_wdata=0010) while in_valid=1 -> in_ready=0; the following ADC 1+1 gives 3.
REQ-039 SHALL cover reset asserted with out_valid=1 and out_ready=0 -> next cycle out_valid=0, flags=0000; also a WIDTH=8 run of ADD 0xFF+1 -> 0x00, NZCV=0110.

Source files
------------

// File: rtl/arm_alu_pipe_pkg.sv
// Shared ARM data-processing definitions.
// Holds the 4-bit opcode encoding used by the ALU and the bit positions of the
// N, Z, C and V flags within the packed NZCV word ({N,Z,C,V}).
package arm_alu_pipe_pkg;

  typedef enum logic [3:0] {
    OpAnd = 4'h0,
    OpEor = 4'h1,
    OpSub = 4'h2,
    OpRsb = 4'h3,
    OpAdd = 4'h4,
    OpAdc = 4'h5,
    OpSbc = 4'h6,
    OpRsc = 4'h7,
    OpTst = 4'h8,
    OpTeq = 4'h9,
    OpCmp = 4'hA,
    OpCmn = 4'hB,
    OpOrr = 4'hC,
    OpMov = 4'hD,
    OpBic = 4'hE,
    OpMvn = 4'hF
  } alu_op_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/arm_alu_pipe_if.sv
// Operation/result bundle between an ALU client and arm_alu_pipe.
// Request side : in_valid/in_ready handshake, op_sel, op1, op2, shifter_carry, set_flags.
// Flag load    : flag_wr, flag_wdata (external NZCV write).
// Result side  : out_valid/out_ready handshake, alu_out, rd_we, flags (NZCV).
// master = client driving operations, slave = the ALU pipe.
interface arm_alu_pipe_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             shifter_carry;
  logic             set_flags;
  logic             flag_wr;
  logic [3:0]       flag_wdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             rd_we;
  logic [3:0]       flags;

  modport master (
    output in_valid, op_sel, op1, op2, shifter_carry, set_flags, flag_wr, flag_wdata, out_ready,
    input  in_ready, out_valid, alu_out, rd_we, flags
  );

  modport slave (
    input  in_valid, op_sel, op1, op2, shifter_carry, set_flags, flag_wr, flag_wdata, out_ready,
    output in_ready, out_valid, alu_out, rd_we, flags
  );

endinterface

// File: rtl/arm_alu_core.sv
// Combinational ARM data-processing ALU.
// Ports:
//   op_sel        opcode (alu_op_e encoding)
//   op1, op2      Rn operand and shifted operand
//   shifter_carry barrel-shifter carry-out, used as C for logical ops
//   set_flags     S bit; when 0 flags_next equals flags_cur
//   flags_cur     current NZCV; C feeds ADC/SBC/RSC
//   result        WIDTH-bit result (wraps modulo 2^WIDTH)
//   rd_we         0 for compare/test ops
//   flags_next    NZCV value to load if the op is accepted
module arm_alu_core
  import arm_alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter bit          SET_C_LOGICAL = 1'b1
) (
  input  logic [3:0]       op_sel,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             shifter_carry,
  input  logic             set_flags,
  input  logic [3:0]       flags_cur,
  output logic [WIDTH-1:0] result,
  output logic             rd_we,
  output logic [3:0]       flags_next
);

  alu_op_e          op;
  logic             is_arith;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   sum;

  assign op = alu_op_e'(op_sel);

  // Every arithmetic form is folded onto one adder: a' + b' + cin.
  always_comb begin
    is_arith  = 1'b0;
    add_a     = op1;
    add_b     = op2;
    add_cin   = 1'b0;
    logic_res = '0;
    unique case (op)
      OpAnd, OpTst: logic_res = op1 & op2;
      OpEor, OpTeq: logic_res = op1 ^ op2;
      OpOrr:        logic_res = op1 | op2;
      OpBic:        logic_res = op1 & ~op2;
      OpMov:        logic_res = op2;
      OpMvn:        logic_res = ~op2;
      OpSub, OpCmp: begin is_arith = 1'b1; add_b = ~op2; add_cin = 1'b1; end
      OpRsb: begin
        is_arith = 1'b1; add_a = op2; add_b = ~op1; add_cin = 1'b1;
      end
      OpAdd, OpCmn: is_arith = 1'b1;
      OpAdc:        begin is_arith = 1'b1; add_cin = flags_cur[FlagC]; end
      OpSbc:        begin is_arith = 1'b1; add_b = ~op2; add_cin = flags_cur[FlagC]; end
      OpRsc: begin
        is_arith = 1'b1; add_a = op2; add_b = ~op1; add_cin = flags_cur[FlagC];
      end
    endcase
  end

  assign sum    = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign result = is_arith ? sum[WIDTH-1:0] : logic_res;
  assign rd_we  = !(op inside {OpTst, OpTeq, OpCmp, OpCmn});

  always_comb begin
    flags_next = flags_cur;
    if (set_flags) begin
      flags_next[FlagN] = result[WIDTH-1];
      flags_next[FlagZ] = (result == '0);
      if (is_arith) begin
        flags_next[FlagC] = sum[WIDTH];
        // Overflow: adder inputs share a sign that the sum does not.
        flags_next[FlagV] = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != add_a[WIDTH-1]);
      end else if (SET_C_LOGICAL) begin
        flags_next[FlagC] = shifter_carry;
      end
    end
  end

endmodule

// File: rtl/arm_alu_pipe.sv
// Single-stage registered ARM ALU with valid/ready handshake on both sides.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         arm_alu_pipe_if slave: operation in, result out, NZCV out,
//               external NZCV load (flag_wr/flag_wdata)
// An op accepted in cycle n shows up on alu_out/rd_we with out_valid in
// cycle n+1, and NZCV updates on the same edge so a following ADC/SBC/RSC
// sees the fresh carry.
module arm_alu_pipe
  import arm_alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter bit          SET_C_LOGICAL = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  arm_alu_pipe_if.slave  bus
);

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             rd_we_q, rd_we_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] core_result;
  logic             core_rd_we;
  logic [3:0]       core_flags;
  logic             in_ready;
  logic             accept;

  arm_alu_core #(
    .WIDTH         (WIDTH),
    .SET_C_LOGICAL (SET_C_LOGICAL)
  ) u_core (
    .op_sel        (bus.op_sel),
    .op1           (bus.op1),
    .op2           (bus.op2),
    .shifter_carry (bus.shifter_carry),
    .set_flags     (bus.set_flags),
    .flags_cur     (flags_q),
    .result        (core_result),
    .rd_we         (core_rd_we),
    .flags_next    (core_flags)
  );

  // Blocking ops during a flag write removes any NZCV write conflict.
  assign in_ready = !reset && !bus.flag_wr && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    alu_out_d   = alu_out_q;
    rd_we_d     = rd_we_q;
    out_valid_d = out_valid_q;
    flags_d     = flags_q;
    if (accept) begin
      alu_out_d   = core_result;
      rd_we_d     = core_rd_we;
      out_valid_d = 1'b1;
      flags_d     = core_flags;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bus.flag_wr) begin
      flags_d = bus.flag_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q   <= '0;
      rd_we_q     <= 1'b0;
      out_valid_q <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      alu_out_q   <= alu_out_d;
      rd_we_q     <= rd_we_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = alu_out_q;
  assign bus.rd_we     = rd_we_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_arm_alu_pipe.sv
// Scoreboard bench for arm_alu_pipe: a 32-bit instance (logical ops load C)
// and an 8-bit instance (logical ops keep C). Directed ops push hand-computed
// {result, rd_we, NZCV} entries; monitors pop them when a result is taken.
module tb_arm_alu_pipe;
  import arm_alu_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        we;
    logic [3:0]  nzcv;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb32[$];
  exp_t sb8[$];
  exp_t mon32_e;
  exp_t mon8_e;

  always #5 clk = ~clk;

  arm_alu_pipe_if #(.WIDTH(32)) bus32 ();
  arm_alu_pipe_if #(.WIDTH(8))  bus8 ();

  arm_alu_pipe #(.WIDTH(32), .SET_C_LOGICAL(1'b1)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  arm_alu_pipe #(.WIDTH(8), .SET_C_LOGICAL(1'b0)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: in_ready never rose, got 0 expected 1", name);
  endtask

  // Called at posedge+1; returns at posedge+1 after the op is accepted.
  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sc, input logic s,
                         input logic [31:0] er, input logic ew, input logic [3:0] ef);
    bit done = 1'b0;
    bus32.in_valid = 1'b1; bus32.op_sel = op; bus32.op1 = a; bus32.op2 = b;
    bus32.shifter_carry = sc; bus32.set_flags = s;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus32.in_ready) begin
        sb32.push_back({er, ew, ef});
        done = 1'b1;
      end
    end
    if (!done) timeout_fail("issue32_timeout");
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic sc, input logic s,
                        input logic [7:0] er, input logic ew, input logic [3:0] ef);
    bit done = 1'b0;
    bus8.in_valid = 1'b1; bus8.op_sel = op; bus8.op1 = a; bus8.op2 = b;
    bus8.shifter_carry = sc; bus8.set_flags = s;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        sb8.push_back({24'h0, er, ew, ef});
        done = 1'b1;
      end
    end
    if (!done) timeout_fail("issue8_timeout");
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus32.out_valid && bus32.out_ready) begin
      if (sb32.size() == 0) begin
        checks++; failures++;
        $display("FAIL out32_unexpected: got result %0h expected none", bus32.alu_out);
      end else begin
        mon32_e = sb32.pop_front();
        check("out32_alu_out", 64'(bus32.alu_out), 64'(mon32_e.res));
        check("out32_rd_we",   64'(bus32.rd_we),   64'(mon32_e.we));
        check("out32_nzcv",    64'(bus32.flags),   64'(mon32_e.nzcv));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus8.out_valid && bus8.out_ready) begin
      if (sb8.size() == 0) begin
        checks++; failures++;
        $display("FAIL out8_unexpected: got result %0h expected none", bus8.alu_out);
      end else begin
        mon8_e = sb8.pop_front();
        check("out8_alu_out", 64'(bus8.alu_out), 64'(mon8_e.res[7:0]));
        check("out8_rd_we",   64'(bus8.rd_we),   64'(mon8_e.we));
        check("out8_nzcv",    64'(bus8.flags),   64'(mon8_e.nzcv));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus32.in_valid = 1'b0; bus32.op_sel = 4'h0; bus32.op1 = '0; bus32.op2 = '0;
    bus32.shifter_carry = 1'b0; bus32.set_flags = 1'b0; bus32.flag_wr = 1'b0;
    bus32.flag_wdata = 4'h0; bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op_sel = 4'h0; bus8.op1 = '0; bus8.op2 = '0;
    bus8.shifter_carry = 1'b0; bus8.set_flags = 1'b0; bus8.flag_wr = 1'b0;
    bus8.flag_wdata = 4'h0; bus8.out_ready = 1'b1;

    // Reset state; in_ready must stay low while reset is high.
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready32", 64'(bus32.in_ready), 64'd0);
      check("rst_in_ready8",  64'(bus8.in_ready),  64'd0);
    end
    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_alu_out",   64'(bus32.alu_out),   64'd0);
    check("rst_rd_we",     64'(bus32.rd_we),     64'd0);
    check("rst_flags",     64'(bus32.flags),     64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // op, a, b, shifter_carry, S, expected result, rd_we, NZCV
    issue32(OpAdd, 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h8000_0000, 1'b1, 4'b1001);
    issue32(OpTst, 32'hF0,        32'h0F,        1'b1, 1'b1, 32'h0,         1'b0, 4'b0111);
    issue32(OpSub, 32'h0,         32'h1,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b1000);
    issue32(OpSbc, 32'h5,         32'h2,         1'b0, 1'b1, 32'h2,         1'b1, 4'b0010);
    issue32(OpCmp, 32'h5,         32'h5,         1'b0, 1'b1, 32'h0,         1'b0, 4'b0110);
    issue32(OpMov, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 4'b0110);
    issue32(OpEor, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b1, 32'hF0F0_F0F0, 1'b1, 4'b1000);
    issue32(OpOrr, 32'h1,         32'h8000_0000, 1'b0, 1'b0, 32'h8000_0001, 1'b1, 4'b1000);
    issue32(OpBic, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 4'b1010);
    issue32(OpMvn, 32'h0,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b1000);
    issue32(OpRsb, 32'h3,         32'hA,         1'b0, 1'b1, 32'h7,         1'b1, 4'b0010);
    issue32(OpRsc, 32'h3,         32'hA,         1'b0, 1'b1, 32'h7,         1'b1, 4'b0010);
    issue32(OpCmn, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h0,         1'b0, 4'b0110);
    issue32(OpTeq, 32'h8000_0000, 32'h0,         1'b0, 1'b1, 32'h8000_0000, 1'b0, 4'b1000);
    issue32(OpAnd, 32'hF0F0,      32'hFF00,      1'b1, 1'b0, 32'hF000,      1'b1, 4'b1000);
    @(posedge clk); #1;

    // Back-pressure: result held, new op refused, then a bubble-free stream.
    bus32.out_ready = 1'b0;
    issue32(OpAdd, 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b1, 4'b1000);
    bus32.in_valid = 1'b1; bus32.op_sel = OpSub; bus32.op1 = 32'hA; bus32.op2 = 32'h3;
    bus32.set_flags = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready",  64'(bus32.in_ready),  64'd0);
      check("hold_out_valid", 64'(bus32.out_valid), 64'd1);
      check("hold_alu_out",   64'(bus32.alu_out),   64'd3);
    end
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    issue32(OpSub, 32'hA, 32'h3, 1'b0, 1'b1, 32'h7,         1'b1, 4'b0010);
    issue32(OpAdc, 32'h1, 32'h1, 1'b0, 1'b1, 32'h3,         1'b1, 4'b0000);
    issue32(OpSbc, 32'h5, 32'h5, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b1000);

    // External flag write blocks acceptance; the next ADC uses the written C.
    bus32.flag_wr = 1'b1; bus32.flag_wdata = 4'b0010;
    bus32.in_valid = 1'b1; bus32.op_sel = OpAdc; bus32.op1 = 32'h1; bus32.op2 = 32'h1;
    @(negedge clk);
    check("flag_wr_in_ready", 64'(bus32.in_ready), 64'd0);
    @(posedge clk); #1;
    bus32.flag_wr = 1'b0;
    check("flag_wr_flags", 64'(bus32.flags), 64'b0010);
    check("flag_wr_no_accept", 64'(bus32.out_valid), 64'd0);
    issue32(OpAdc, 32'h1, 32'h1, 1'b0, 1'b1, 32'h3, 1'b1, 4'b0000);
    @(posedge clk); #1;

    // Reset drops a held result and ignores a concurrent flag write.
    bus32.out_ready = 1'b0;
    issue32(OpAdd, 32'h4, 32'h4, 1'b0, 1'b1, 32'h8, 1'b1, 4'b0000);
    check("pre_reset_out_valid", 64'(bus32.out_valid), 64'd1);
    reset = 1'b1;
    bus32.flag_wr = 1'b1; bus32.flag_wdata = 4'b1111;
    @(negedge clk);
    check("reset_in_ready", 64'(bus32.in_ready), 64'd0);
    @(posedge clk); #1;
    check("reset_out_valid", 64'(bus32.out_valid), 64'd0);
    check("reset_flags",     64'(bus32.flags),     64'd0);
    check("reset_alu_out",   64'(bus32.alu_out),   64'd0);
    check("reset_rd_we",     64'(bus32.rd_we),     64'd0);
    reset = 1'b0;
    bus32.flag_wr = 1'b0;
    bus32.out_ready = 1'b1;
    sb32.delete();

    // 8-bit instance; logical ops keep C here.
    issue8(OpAdd, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 4'b0110);
    issue8(OpSub, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 4'b0011);
    issue8(OpAnd, 8'hF0, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 4'b0111);
    issue8(OpMvn, 8'h00, 8'h0F, 1'b0, 1'b1, 8'hF0, 1'b1, 4'b1011);

    repeat (3) @(posedge clk);
    #1;
    check("sb32_drained", 64'(sb32.size()), 64'd0);
    check("sb8_drained",  64'(sb8.size()),  64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
